// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 timing constants shared by the sync generator and pixel renderers.
// Sync windows are precomputed so consumers never re-derive porch arithmetic.
package vga_timing_pkg;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] coord_t;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int V_DISPLAY = 480;
    localparam int V_BOTTOM  = 10;
    localparam int V_SYNC    = 2;
    localparam int V_TOP     = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    // Inclusive window test on a coordinate, bounds given as full-width constants.
    function automatic logic in_window(input coord_t pos, input coord_t lo, input coord_t hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Purpose: modulo-(MAX+1) counter that advances on inc and flags the wrapping step.
// Latency: cnt updates one clock after inc; wrap is a same-cycle decode of cnt and inc.
// Backpressure: none, the counter is free-running whenever inc is high.
module mod_counter #(
    parameter int WIDTH = 10,
    parameter int MAX   = 799
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    assign wrap = inc && (cnt == MAX_V);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vga_hvsync_generator.sv
// Purpose: free-running VGA raster timing (sync pulses, visible flag, pixel coordinates).
// Latency: sync/display_on are zero-latency decodes of the registered hpos/vpos.
// Backpressure: none, the raster never stalls.
module vga_hvsync_generator
    import vga_timing_pkg::*;
#(
    parameter int   H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int   H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK    = vga_timing_pkg::H_BACK,
    parameter int   V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int   V_BOTTOM  = vga_timing_pkg::V_BOTTOM,
    parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int   V_TOP     = vga_timing_pkg::V_TOP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        hsync,
    output logic        vsync,
    output logic        display_on,
    output logic [9:0]  hpos,
    output logic [9:0]  vpos
);

    localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

    localparam coord_t H_MAX    = coord_t'(H_TOT - 1);
    localparam coord_t V_MAX    = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_DISPLAY + V_BOTTOM);
    localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    logic h_wrap;
    logic v_wrap;

    mod_counter #(.WIDTH(CNT_W), .MAX(H_TOT - 1)) u_hcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .cnt   (hpos),
        .wrap  (h_wrap)
    );

    // The line counter only steps on the last pixel of each line.
    mod_counter #(.WIDTH(CNT_W), .MAX(V_TOT - 1)) u_vcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (h_wrap),
        .cnt   (vpos),
        .wrap  (v_wrap)
    );

    assign hsync      = in_window(hpos, HS_START, HS_END) ? HSYNC_POL : !HSYNC_POL;
    assign vsync      = in_window(vpos, VS_START, VS_END) ? VSYNC_POL : !VSYNC_POL;
    assign display_on = (hpos < H_VIS) && (vpos < V_VIS);

    // A frame wrap can only happen at the last pixel of the last line.
    a_frame_wrap: assert property (@(posedge clk) disable iff (!rst_n)
        v_wrap |-> (hpos == H_MAX) && (vpos == V_MAX));

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// Scoreboarded bench: a full-size raster plus a shrunken, inverted-polarity raster for whole-frame checks.
module tb_vga_hvsync_generator;

    localparam int NCYC = 9000;

    // Shrunken timing so several whole frames fit in the run.
    localparam int SHD = 10, SHF = 2, SHS = 3, SHB = 1;
    localparam int SVD = 6,  SVB = 2, SVS = 2, SVT = 3;
    localparam int SHT = SHD + SHF + SHS + SHB;
    localparam int SVTOT = SVD + SVB + SVS + SVT;

    typedef struct {
        int   h;
        int   v;
        logic hs;
        logic vs;
        logic de;
        logic rst;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic       a_hsync, a_vsync, a_de;
    logic [9:0] a_hpos, a_vpos;
    logic       b_hsync, b_vsync, b_de;
    logic [9:0] b_hpos, b_vpos;

    vga_hvsync_generator u_dut_a (
        .clk        (clk),
        .rst_n      (rst_a),
        .hsync      (a_hsync),
        .vsync      (a_vsync),
        .display_on (a_de),
        .hpos       (a_hpos),
        .vpos       (a_vpos)
    );

    vga_hvsync_generator #(
        .H_DISPLAY (SHD), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
        .V_DISPLAY (SVD), .V_BOTTOM(SVB), .V_SYNC (SVS), .V_TOP  (SVT),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b1)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_b),
        .hsync      (b_hsync),
        .vsync      (b_vsync),
        .display_on (b_de),
        .hpos       (b_hpos),
        .vpos       (b_vpos)
    );

    int n_checks = 0;
    int n_errors = 0;

    exp_t qa[$];
    exp_t qb[$];

    // Raster position is just the number of pixel clocks since reset, folded by line and frame length.
    function automatic exp_t model(input int n, input int hd, input int hf, input int hs, input int hb,
                                   input int vd, input int vb, input int vs, input int vt,
                                   input logic hpol, input logic vpol, input logic r);
        exp_t e;
        int   ht;
        int   vtot;
        ht    = hd + hf + hs + hb;
        vtot  = vd + vb + vs + vt;
        e.h   = n % ht;
        e.v   = (n / ht) % vtot;
        e.hs  = (e.h >= hd + hf && e.h < hd + hf + hs) ? hpol : ~hpol;
        e.vs  = (e.v >= vd + vb && e.v < vd + vb + vs) ? vpol : ~vpol;
        e.de  = (e.h < hd) && (e.v < vd);
        e.rst = r;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp, input int cyc);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            if (n_errors <= 30)
                $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic stimulus();
        int   na = 0;
        int   nb = 0;
        bit   mid_a = 0;
        bit   mid_b = 0;
        exp_t ca, cb;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            ca = model(na, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1'b0);
            cb = model(nb, SHD, SHF, SHS, SHB, SVD, SVB, SVS, SVT, 1'b1, 1'b1, 1'b0);
            rst_a = 1'b1;
            rst_b = 1'b1;
            if (cyc < 3) begin
                rst_a = 1'b0;
                rst_b = 1'b0;
            end else begin
                if (!mid_a && ca.h == 700 && ca.v == 3) begin
                    rst_a = 1'b0;
                    mid_a = 1;
                end
                if (!mid_b && cb.h == 12 && cb.v == 7) begin
                    rst_b = 1'b0;
                    mid_b = 1;
                end
                if (cyc >= 2000 && cyc < 5000 && $urandom_range(0, 299) == 0)
                    rst_b = 1'b0;
            end
            na = rst_a ? na + 1 : 0;
            nb = rst_b ? nb + 1 : 0;
            qa.push_back(model(na, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, !rst_a));
            qb.push_back(model(nb, SHD, SHF, SHS, SHB, SVD, SVB, SVS, SVT, 1'b1, 1'b1, !rst_b));
            @(negedge clk);
        end
    endtask

    task automatic monitor();
        exp_t ea, eb;
        bit   have_edge = 0;
        bit   prev_vs = 0;
        bit   prev_hs = 0;
        int   last_edge = 0;
        int   hs_pulses = 0;
        bit   cur_vs, cur_hs;
        for (int k = 0; k < NCYC; k++) begin
            @(posedge clk);
            #1;
            if (qa.size() == 0 || qb.size() == 0) begin
                check("scoreboard_empty", 0, 1, k);
                continue;
            end
            ea = qa.pop_front();
            eb = qb.pop_front();
            check("a_hpos",  int'(a_hpos),  ea.h,       k);
            check("a_vpos",  int'(a_vpos),  ea.v,       k);
            check("a_hsync", int'(a_hsync), int'(ea.hs), k);
            check("a_vsync", int'(a_vsync), int'(ea.vs), k);
            check("a_de",    int'(a_de),    int'(ea.de), k);
            check("b_hpos",  int'(b_hpos),  eb.h,       k);
            check("b_vpos",  int'(b_vpos),  eb.v,       k);
            check("b_hsync", int'(b_hsync), int'(eb.hs), k);
            check("b_vsync", int'(b_vsync), int'(eb.vs), k);
            check("b_de",    int'(b_de),    int'(eb.de), k);

            // Whole-frame measurements between uninterrupted active vsync edges.
            cur_vs = (b_vsync == 1'b1);
            cur_hs = (b_hsync == 1'b1);
            if (eb.rst) begin
                have_edge = 0;
                hs_pulses = 0;
            end else begin
                if (cur_hs && !prev_hs)
                    hs_pulses++;
                if (cur_vs && !prev_vs) begin
                    if (have_edge) begin
                        check("b_frame_period", k - last_edge, SHT * SVTOT, k);
                        check("b_hsync_per_frame", hs_pulses, SVTOT, k);
                    end
                    have_edge = 1;
                    last_edge = k;
                    hs_pulses = 0;
                end
            end
            prev_vs = cur_vs;
            prev_hs = cur_hs;
        end
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        fork
            stimulus();
            monitor();
        join
        if (qa.size() != 0 || qb.size() != 0)
            check("scoreboard_leftover", qa.size() + qb.size(), 0, NCYC);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
